// File: rtl/dcmi_tx_pingpong.sv
// Double-buffered DCMI frame transmitter: the host fills one bank while the
// other bank is streamed out on the DCMI pins with a generated pixel clock.
module dcmi_tx_pingpong #(
    parameter int DATA_W   = 8,
    parameter int LEN_BITS = 10,
    parameter int DIV_BITS = 1,
    parameter int GAP      = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W-1:0]   DI,
    input  logic                WR,
    input  logic                WR_RST,
    input  logic                START,
    output logic                READY,
    output logic                BUSY,
    output logic                OVF,
    output logic [LEN_BITS:0]   WLEN,
    output logic [DATA_W-1:0]   DATA,
    output logic                DSYNC,
    output logic                DCLK,
    output logic                CLKEN
);

    localparam int MAX_LEN = 1 << LEN_BITS;
    localparam int GCNT_W  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAPW   = 2'd2;

    localparam logic [LEN_BITS:0] LEN_ONE  = (LEN_BITS+1)'(1);
    localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);
    localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_INIT = GCNT_W'(GAP - 1);

    // Both banks share one array; the bank select is the top address bit.
    logic [DATA_W-1:0]   r_mem [0:2*MAX_LEN-1];

    logic [DIV_BITS-1:0] r_div;
    logic                r_wb;
    logic                r_rb;
    logic                r_pend;
    logic                r_ovf;
    logic                r_dsync;
    logic [LEN_BITS:0]   r_wlen;
    logic [LEN_BITS:0]   r_plen;
    logic [LEN_BITS:0]   r_raddr;
    logic [1:0]          r_state;
    logic [GCNT_W-1:0]   r_gcnt;
    logic [DATA_W-1:0]   r_data;

    logic                w_clken;
    logic                w_full;
    logic                w_wr_ok;
    logic                w_ready;
    logic                w_start;
    logic                w_load;
    logic [LEN_BITS-1:0] w_rd_idx;

    assign w_clken  = &r_div;
    assign w_full   = r_wlen[LEN_BITS];
    assign w_wr_ok  = WR && !WR_RST && !w_full;
    assign w_ready  = (r_wlen != '0) && !r_pend && (r_state == ST_IDLE);
    assign w_start  = START && !WR_RST && w_ready;

    // A word is fetched on the CLKEN edge that opens each DSYNC-high period.
    assign w_load   = w_clken &&
                      (((r_state == ST_IDLE) && r_pend) ||
                       ((r_state == ST_ACTIVE) && (r_raddr != r_plen)));
    assign w_rd_idx = (r_state == ST_IDLE) ? '0 : r_raddr[LEN_BITS-1:0];

    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[{r_wb, r_wlen[LEN_BITS-1:0]}] <= DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_load) begin
            r_data <= r_mem[{r_rb, w_rd_idx}];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div   <= '0;
            r_wb    <= 1'b0;
            r_rb    <= 1'b0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dsync <= 1'b0;
            r_wlen  <= '0;
            r_plen  <= '0;
            r_raddr <= '0;
            r_state <= ST_IDLE;
            r_gcnt  <= '0;
        end else begin
            r_div <= r_div + DIV_ONE;

            if (WR_RST) begin
                r_wlen <= '0;
                r_ovf  <= 1'b0;
            end else if (w_start) begin
                // A write in the commit cycle lands in the old bank and counts.
                r_pend <= 1'b1;
                r_plen <= w_wr_ok ? (r_wlen + LEN_ONE) : r_wlen;
                r_rb   <= r_wb;
                r_wb   <= ~r_wb;
                r_wlen <= '0;
                r_ovf  <= 1'b0;
            end else if (WR) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wlen <= r_wlen + LEN_ONE;
                end
            end

            if (w_clken) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_pend) begin
                            r_raddr <= LEN_ONE;
                            r_dsync <= 1'b1;
                            r_pend  <= 1'b0;
                            r_state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (r_raddr == r_plen) begin
                            r_dsync <= 1'b0;
                            r_gcnt  <= GCNT_INIT;
                            r_state <= ST_GAPW;
                        end else begin
                            r_raddr <= r_raddr + LEN_ONE;
                        end
                    end
                    ST_GAPW: begin
                        if (r_gcnt == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gcnt <= r_gcnt - GCNT_ONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // The read register is not reset; DSYNC gating keeps DATA at 0 instead.
    assign DATA  = r_dsync ? r_data : '0;
    assign DSYNC = r_dsync;
    assign DCLK  = r_div[DIV_BITS-1];
    assign CLKEN = w_clken;
    assign READY = w_ready;
    assign BUSY  = r_pend || (r_state != ST_IDLE);
    assign OVF   = r_ovf;
    assign WLEN  = r_wlen;

endmodule

// File: tb/tb_dcmi_tx_pingpong.sv
// Scoreboard bench for dcmi_tx_pingpong: committed frames are queued as
// expected word streams and a negedge monitor checks the DCMI pins.
module tb_dcmi_tx_pingpong;

    localparam int DATA_W   = 8;
    localparam int LEN_BITS = 3;
    localparam int DIV_BITS = 2;
    localparam int GAP      = 2;
    localparam int MAX_LEN  = 1 << LEN_BITS;
    localparam int DIVN     = 1 << DIV_BITS;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [DATA_W-1:0] DI = '0;
    logic              WR = 1'b0;
    logic              WR_RST = 1'b0;
    logic              START = 1'b0;
    logic              READY, BUSY, OVF, DSYNC, DCLK, CLKEN;
    logic [LEN_BITS:0] WLEN;
    logic [DATA_W-1:0] DATA;

    dcmi_tx_pingpong #(
        .DATA_W(DATA_W), .LEN_BITS(LEN_BITS), .DIV_BITS(DIV_BITS), .GAP(GAP)
    ) dut (
        .CLK(CLK), .RST(RST), .DI(DI), .WR(WR), .WR_RST(WR_RST), .START(START),
        .READY(READY), .BUSY(BUSY), .OVF(OVF), .WLEN(WLEN),
        .DATA(DATA), .DSYNC(DSYNC), .DCLK(DCLK), .CLKEN(CLKEN)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: write bank contents, overflow flag, committed frames.
    int wq[$];
    int movf = 0;
    int starts = 0;
    int idles = 0;
    int exp_words[$];
    int exp_lens[$];
    int dcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            if (RST) dcnt = 0;
            else dcnt++;
        end
    end

    // Monitor: all DUT sampling happens on the falling edge.
    initial begin
        int prev_ds, prev_ce, in_gap, rel, had, gcnt, lowcnt, seen, lat;
        int cur_len, ccnt, cur_w;
        bit newp;
        prev_ds = 0; prev_ce = 0; in_gap = 0; rel = 0; had = 0; gcnt = 0;
        lowcnt = 0; seen = 0; lat = 0; cur_len = 0; ccnt = 0; cur_w = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_words.delete();
                exp_lens.delete();
                idles = 0; seen = 0; lat = 0;
                prev_ds = 0; prev_ce = 0; in_gap = 0; rel = 0; had = 0;
                gcnt = 0; lowcnt = 0; ccnt = 0; cur_len = 0;
                continue;
            end
            if (rel != 0) begin
                idles++;
                rel = 0;
            end
            if (starts != seen) begin
                seen = starts;
                lat = 0;
            end
            chk("clken", int'(CLKEN), int'((dcnt % DIVN) == DIVN - 1));
            chk("dclk", int'(DCLK), int'((dcnt % DIVN) >= DIVN / 2));
            chk("busy", int'(BUSY), int'(starts != idles));
            chk("ready", int'(READY), int'(wq.size() != 0 && starts == idles));
            chk("wlen", int'(WLEN), wq.size());
            chk("ovf", int'(OVF), movf);

            newp = 1'b0;
            if (DSYNC && prev_ds == 0) begin
                chk("start_latency", lat, 1);
                if (had != 0) chk("gap_ok", int'(lowcnt >= GAP + 1), 1);
                if (exp_lens.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_frame: got a frame, expected none (t=%0t)", $time);
                    cur_len = 0;
                end else begin
                    cur_len = exp_lens.pop_front();
                end
                ccnt = 0;
                newp = 1'b1;
            end else if (DSYNC && prev_ce != 0) begin
                newp = 1'b1;
            end
            if (newp) begin
                ccnt++;
                if (ccnt <= cur_len && exp_words.size() != 0) begin
                    cur_w = exp_words.pop_front();
                end else begin
                    chk("frame_overrun", ccnt, cur_len);
                    cur_w = -1;
                end
            end
            if (DSYNC) chk("data", int'(DATA), cur_w);
            else chk("data_idle", int'(DATA), 0);

            if (!DSYNC && prev_ds != 0) begin
                chk("frame_len", ccnt, cur_len);
                had = 1; lowcnt = 0; gcnt = 0; in_gap = 1;
            end
            if (!DSYNC && CLKEN) lowcnt++;
            if (in_gap != 0 && CLKEN) begin
                gcnt++;
                if (gcnt == GAP) begin
                    rel = 1;
                    in_gap = 0;
                end
            end
            if (CLKEN) lat++;
            prev_ds = int'(DSYNC);
            prev_ce = int'(CLKEN);
        end
    end

    // One CLK of stimulus; the model applies what the DUT samples at the edge.
    task automatic cyc(input bit wr, input int di, input bit st, input bit wrst, output bit acc);
        bit rdy;
        WR = wr; DI = di[DATA_W-1:0]; START = st; WR_RST = wrst;
        @(posedge CLK);
        rdy = (wq.size() != 0) && (starts == idles);
        acc = 1'b0;
        if (wrst) begin
            wq.delete();
            movf = 0;
        end else begin
            if (wr) begin
                if (wq.size() < MAX_LEN) wq.push_back(di & 255);
                else movf = 1;
            end
            if (st && rdy) begin
                acc = 1'b1;
                exp_lens.push_back(wq.size());
                foreach (wq[i]) exp_words.push_back(wq[i]);
                wq.delete();
                movf = 0;
                starts++;
            end
        end
        #2;
        WR = 1'b0; START = 1'b0; WR_RST = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) cyc(1'b0, 0, 1'b0, 1'b0, a);
    endtask

    task automatic wr_word(input int d);
        bit a;
        cyc(1'b1, d, 1'b0, 1'b0, a);
    endtask

    task automatic pulse_start();
        bit a;
        cyc(1'b0, 0, 1'b1, 1'b0, a);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!(wq.size() != 0 && starts == idles) && t < 1000) begin
            idle(1);
            t++;
        end
        if (t >= 1000) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (starts != idles && t < 2000) begin
            idle(1);
            t++;
        end
        if (t >= 2000) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int t;
        #12;
        chk("rst_data", int'(DATA), 0);
        chk("rst_dsync", int'(DSYNC), 0);
        chk("rst_dclk", int'(DCLK), 0);
        chk("rst_clken", int'(CLKEN), 0);
        chk("rst_ready", int'(READY), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_ovf", int'(OVF), 0);
        chk("rst_wlen", int'(WLEN), 0);
        @(posedge CLK); #2;
        RST = 1'b0;
        idle(3);

        // Basic three-word frame.
        wr_word(8'h11); wr_word(8'h22); wr_word(8'h33);
        pulse_start();
        wait_done();
        idle(4);

        // Full bank with one dropped word.
        for (int i = 0; i < MAX_LEN; i++) wr_word(i);
        wr_word(8'hFF);
        idle(1);
        chk("full_ovf", int'(OVF), 1);
        chk("full_wlen", int'(WLEN), MAX_LEN);
        pulse_start();
        chk("ovf_cleared", int'(OVF), 0);
        wait_done();
        idle(3);

        // START with an empty write bank.
        pulse_start();
        idle(3);
        chk("empty_start_busy", int'(BUSY), 0);

        // Ping-pong: B is written and START refused while A is on the wire.
        for (int i = 0; i < 4; i++) wr_word(8'hA0 + i);
        pulse_start();
        for (int i = 0; i < 5; i++) wr_word(8'hB0 + i);
        chk("pp_ready_low", int'(READY), 0);
        pulse_start();
        chk("pp_still_busy", int'(BUSY), 1);
        chk("pp_b_held", int'(WLEN), 5);
        wait_ready();
        pulse_start();
        wait_done();
        idle(3);

        // WR and START together: the word joins the committed frame.
        wr_word(8'h5A); wr_word(8'h5B);
        cyc(1'b1, 8'h5C, 1'b1, 1'b0, a);
        chk("wr_start_wlen", int'(WLEN), 0);
        wait_done();
        idle(3);

        // WR_RST and START together: nothing is sent.
        wr_word(8'h66); wr_word(8'h67);
        cyc(1'b1, 8'h68, 1'b1, 1'b1, a);
        idle(6);
        chk("wrrst_wlen", int'(WLEN), 0);
        chk("wrrst_busy", int'(BUSY), 0);

        // Randomized frames, written while the previous one streams.
        for (int f = 0; f < 10; f++) begin
            int len;
            len = $urandom_range(1, MAX_LEN + 2);
            for (int w = 0; w < len; w++) begin
                idle($urandom_range(0, 2));
                cyc(1'b1, $urandom_range(0, 255), ($urandom_range(0, 7) == 0), 1'b0, a);
            end
            if (wq.size() != 0) begin
                wait_ready();
                pulse_start();
            end
        end
        wait_done();
        idle(3);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 6; i++) wr_word(8'hC0 + i);
        pulse_start();
        wr_word(8'h77);
        t = 0;
        while (!DSYNC && t < 100) begin
            idle(1);
            t++;
        end
        if (t >= 100) chk("dsync_timeout", 0, 1);
        idle(5);
        #1;
        RST = 1'b1;
        starts = 0;
        wq.delete();
        movf = 0;
        #1;
        chk("midrst_dsync", int'(DSYNC), 0);
        chk("midrst_data", int'(DATA), 0);
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_wlen", int'(WLEN), 0);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        idle(2);
        wr_word(8'hE1); wr_word(8'hE2);
        pulse_start();
        wait_done();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dcmi_tx_pingpong.md
# dcmi_tx_pingpong

Double-buffered DCMI frame transmitter with built-in DCMI clock generation. A host-side writer fills one RAM bank while the other bank is being sent, so frames go out back to back without waiting for a buffer drain. The block sits between the host register/FIFO interface and the DCMI pins, replacing the single-buffer transmitter where continuous streaming is required. Pixel width, bank depth, DCMI clock division and inter-frame gap are all parameters.

## Interface
Parameters:
- DATA_W, 8: DCMI data width; legal range 8..14.
- LEN_BITS, 10: bank address bits; bank depth MAX_LEN = 2^LEN_BITS words.
- DIV_BITS, 1: DCMI clock divider bits; DCLK = CLK / 2^DIV_BITS; must be >= 1.
- GAP, 2: minimum idle CLKEN periods with DSYNC low between frames; must be >= 1.

Ports:
- CLK  in  1  global clock.
- RST  in  1  asynchronous, active-high reset.
- DI  in  DATA_W  write data.
- WR  in  1  write strobe; one word per CLK.
- WR_RST  in  1  clears the write bank length and overflow flag.
- START  in  1  commits the write bank for transmission.
- READY  out  1  START would be accepted this cycle.
- BUSY  out  1  a frame is committed, transmitting or in its gap.
- OVF  out  1  sticky write-overflow flag.
- WLEN  out  LEN_BITS+1  words held in the write bank.
- DATA  out  DATA_W  DCMI data; forced to 0 while DSYNC is low.
- DSYNC  out  1  DCMI frame-valid.
- DCLK  out  1  DCMI pixel clock.
- CLKEN  out  1  one-CLK strobe on which DCMI outputs update.

## Operation
- Divider: DIV_BITS counter, incremented every CLK. DCLK is its MSB. CLKEN = all ones. DATA and DSYNC change only on the CLK edge that follows CLKEN, which coincides with the DCLK falling edge.
- Banks: two banks of MAX_LEN x DATA_W, with synchronous write and read. WB selects the write bank; the transmitter reads bank RB.
- Write path:
  - WR with WLEN < MAX_LEN: ram[WB][WLEN] <= DI, then WLEN++.
  - WR with WLEN == MAX_LEN: the word is dropped and OVF <= 1.
- WR_RST: WLEN <= 0 and OVF <= 0. WR_RST has priority over WR and START in the same cycle; both are ignored.
- READY = (WLEN != 0) && !PEND && TX state == IDLE.
  - This means the other bank is fully free.
- START when READY is high:
  - PEND <= 1, PLEN <= WLEN, RB <= WB.
  - WB <= ~WB, WLEN <= 0, OVF <= 0.
- START when READY is low: ignored; no state change.
- WR and START in the same cycle: the write lands in the old bank first and is included in PLEN.
- TX state machine; advances only on CLKEN:
  - IDLE: if PEND, then data_out <= ram[RB][0], RADDR <= 1, DSYNC <= 1, PEND <= 0, go to ACTIVE.
  - ACTIVE: if RADDR == PLEN, then DSYNC <= 0, GCNT <= GAP-1, go to GAPW. Otherwise data_out <= ram[RB][RADDR] and RADDR++.
  - GAPW: if GCNT == 0, go to IDLE; otherwise GCNT--.
- RADDR and PLEN are LEN_BITS+1 wide, so a full bank (PLEN = MAX_LEN) sends every word without wrapping.
- BUSY = PEND || state != IDLE.
- Streaming: while bank RB transmits, the host fills WB. START for that bank is refused until the transmitter returns to IDLE. The host polls READY.

## Timing
- Reset values: all outputs 0, including DATA, DSYNC, DCLK, CLKEN (divider = 0), READY, BUSY, OVF and WLEN. Internally WB=0, RB=0, PEND=0, state IDLE.
- Reset mid-frame: DSYNC and DATA go to 0 immediately (asynchronous). Bank contents are undefined after reset.
- START to DSYNC rise: the first CLKEN strictly after the START cycle, plus one CLK.
- A frame of N words holds DSYNC high for exactly N CLKEN periods, i.e. N*2^DIV_BITS CLK. Word k is presented during the k-th period.
- DSYNC stays low for at least GAP+1 CLKEN periods before the next frame.
- READY rises one CLK after the GAPW-to-IDLE transition, provided WLEN != 0.

## Test plan
- DIV_BITS=2, LEN_BITS=3, GAP=2: write 0x11, 0x22, 0x33, then START. Required response:
  - DCLK period is 4 CLK and CLKEN occurs every 4th CLK.
  - DSYNC is high for 12 CLK and DATA sequences 0x11, 0x22, 0x33, 4 CLK each.
  - DATA is 0 outside the frame.
- Full bank: write 8 words 0..7, then a 9th word 0xFF. Required response: OVF=1 and WLEN=8. After START, 8 words 0..7 are sent; 0xFF never appears and OVF clears.
- Ping-pong: START frame A (4 words). During A, write frame B (5 words) and pulse START. Required response:
  - This START is ignored (READY=0).
  - READY rises after A's gap.
  - A re-issued START sends B after at least 3 idle CLKEN periods with DSYNC low.
- Simultaneous events:
  - WR and START in the same cycle: the word is included, and PLEN equals the prior WLEN+1.
  - WR_RST and START in the same cycle: no frame is sent and WLEN=0.
- START with WLEN=0: ignored, and BUSY stays 0.
- Assert RST in the middle of frame transmission. Required response:
  - DSYNC, DATA, BUSY and WLEN are 0 within the same cycle.
  - After release, a new 2-word frame transmits correctly from bank 0.
